// File: rtl/vend_pkg.sv
// Shared types and constants for the coin-operated vending credit controller.
// FSM state encoding, decoded coin values and default price/ceiling settings.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_REFUND  = 2'd3
  } state_t;

  localparam logic [3:0] COIN_NONE = 4'd0;
  localparam logic [3:0] COIN_1    = 4'd1;
  localparam logic [3:0] COIN_2    = 4'd2;
  localparam logic [3:0] COIN_5    = 4'd5;

  localparam int unsigned DEF_PRICE0     = 5;
  localparam int unsigned DEF_PRICE1     = 10;
  localparam int unsigned DEF_PRICE2     = 15;
  localparam int unsigned DEF_PRICE3     = 20;
  localparam int unsigned DEF_MAX_CREDIT = 50;

endpackage

// File: rtl/price_lut.sv
// Item price lookup: maps the 2-bit select onto its configured price.
// Purely combinational, no latency and no flow control.
module price_lut
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned PRICE0   = DEF_PRICE0,
  parameter int unsigned PRICE1   = DEF_PRICE1,
  parameter int unsigned PRICE2   = DEF_PRICE2,
  parameter int unsigned PRICE3   = DEF_PRICE3
) (
  input  logic [1:0]          sel,
  output logic [CREDIT_W-1:0] price
);

  always_comb begin
    price = CREDIT_W'(PRICE0);
    case (sel)
      2'd0:    price = CREDIT_W'(PRICE0);
      2'd1:    price = CREDIT_W'(PRICE1);
      2'd2:    price = CREDIT_W'(PRICE2);
      default: price = CREDIT_W'(PRICE3);
    endcase
  end

endmodule

// File: rtl/credit_ctrl.sv
// Vending credit controller: accumulates coins, vends against credit, refunds the rest.
// All outputs registered, one cycle after the triggering input; no backpressure, refused events pulse a flag.
module credit_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int unsigned PRICE0     = DEF_PRICE0,
  parameter int unsigned PRICE1     = DEF_PRICE1,
  parameter int unsigned PRICE2     = DEF_PRICE2,
  parameter int unsigned PRICE3     = DEF_PRICE3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          coin_value,
  input  logic [1:0]          sel,
  input  logic                buy,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [1:0]          item,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                insufficient
);

  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt, change_nxt, price;
  logic [1:0]          item_nxt;
  logic                dispense_nxt, change_valid_nxt, coin_reject_nxt, insufficient_nxt;
  logic                coin_evt;
  logic [CREDIT_W:0]   coin_sum;

  price_lut #(
    .CREDIT_W (CREDIT_W),
    .PRICE0   (PRICE0),
    .PRICE1   (PRICE1),
    .PRICE2   (PRICE2),
    .PRICE3   (PRICE3)
  ) u_price_lut (
    .sel   (sel),
    .price (price)
  );

  // One extra bit so the ceiling test can never be fooled by wrap-around.
  assign coin_evt = (coin_value != COIN_NONE);
  assign coin_sum = {1'b0, credit} + {{(CREDIT_W-3){1'b0}}, coin_value};

  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    item_nxt         = item;
    change_nxt       = change;
    dispense_nxt     = 1'b0;
    change_valid_nxt = 1'b0;
    coin_reject_nxt  = 1'b0;
    insufficient_nxt = 1'b0;
    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (cancel && (state == ST_COLLECT)) begin
          state_nxt        = ST_REFUND;
          change_valid_nxt = 1'b1;
          change_nxt       = credit;
          coin_reject_nxt  = coin_evt;
        end else if (buy) begin
          // A refused buy still claims the cycle, so a same-cycle coin is bounced.
          coin_reject_nxt = coin_evt;
          if (credit >= price) begin
            state_nxt    = ST_VEND;
            dispense_nxt = 1'b1;
            item_nxt     = sel;
            credit_nxt   = credit - price;
          end else begin
            insufficient_nxt = 1'b1;
          end
        end else if (coin_evt) begin
          if (coin_sum <= MAX_SUM) begin
            credit_nxt = coin_sum[CREDIT_W-1:0];
            state_nxt  = ST_COLLECT;
          end else begin
            coin_reject_nxt = 1'b1;
          end
        end
      end
      ST_VEND: begin
        coin_reject_nxt = coin_evt;
        if (credit != '0) begin
          state_nxt        = ST_REFUND;
          change_valid_nxt = 1'b1;
          change_nxt       = credit;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REFUND: begin
        coin_reject_nxt = coin_evt;
        credit_nxt      = '0;
        change_nxt      = '0;
        state_nxt       = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      credit       <= '0;
      item         <= '0;
      change       <= '0;
      dispense     <= 1'b0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      item         <= item_nxt;
      change       <= change_nxt;
      dispense     <= dispense_nxt;
      change_valid <= change_valid_nxt;
      coin_reject  <= coin_reject_nxt;
      insufficient <= insufficient_nxt;
    end
  end

endmodule

// File: doc/credit_ctrl.md
CREDIT_CTRL -- requirements
Module: credit_ctrl

Interface
REQ-001 Parameter CREDIT_W, default 8: width of the credit and change values.
REQ-002 Parameter MAX_CREDIT, default 50: ceiling on accumulated credit, in rupees.
REQ-003 Parameters PRICE0/PRICE1/PRICE2/PRICE3, defaults 5/10/15/20: item prices in rupees, each nonzero and <= MAX_CREDIT.
REQ-004 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n  in  1: asynchronous, active-low reset.
REQ-006 Port coin_value  in  4: decoded coin value (0, 1, 2 or 5); nonzero means one coin event, presented for exactly one cycle per coin.
REQ-007 Port sel  in  2: item select, sampled with buy.
REQ-008 Port buy  in  1: single-cycle purchase request.
REQ-009 Port cancel  in  1: single-cycle refund request.
REQ-010 Port credit  out  CREDIT_W: current registered credit.
REQ-011 Port dispense  out  1: one-cycle pulse; the item is released.
REQ-012 Port item  out  2: index of the dispensed item; valid while dispense=1.
REQ-013 Port change  out  CREDIT_W: amount returned; valid while change_valid=1.
REQ-014 Port change_valid  out  1: one-cycle pulse; change is returned.
REQ-015 Port coin_reject  out  1: one-cycle pulse; the coin from the previous cycle was not credited.
REQ-016 Port insufficient  out  1: one-cycle pulse; the previous buy was refused for lack of credit.

Function
REQ-017 FSM states: IDLE, COLLECT, VEND, REFUND. All outputs are registered.
REQ-018 Coin acceptance in IDLE/COLLECT, nonzero coin_value, no buy/cancel taken, credit+coin_value <= MAX_CREDIT:
- next cycle: credit = credit + coin_value
- next state: COLLECT
REQ-019 Coin with credit+coin_value > MAX_CREDIT: credit unchanged; coin_reject=1 next cycle.
REQ-020 Any nonzero coin_value while in VEND or REFUND, or in the same cycle that a buy/cancel is taken: coin_reject=1 next cycle.
REQ-021 Priority within one cycle is cancel > buy > coin; buy is evaluated against registered credit, not credit plus the same-cycle coin.
REQ-022 buy in IDLE/COLLECT with credit >= PRICE[sel]:
- next cycle: state=VEND, dispense=1, item=sel, credit=credit-PRICE[sel]
- latency from buy to dispense: 1 cycle
REQ-023 buy with credit < PRICE[sel]: insufficient=1 next cycle; credit and state unchanged (IDLE stays IDLE).
REQ-024 VEND lasts one cycle. It then goes to REFUND if credit > 0, else to IDLE.
REQ-025 cancel in COLLECT: next state REFUND. cancel in IDLE, VEND or REFUND is ignored.
REQ-026 REFUND lasts one cycle:
- change_valid=1 and change=credit on entry
- next cycle: credit=0, change=0, state=IDLE
REQ-027 dispense, change_valid, coin_reject and insufficient are never high for more than one consecutive cycle per event.
REQ-028 credit never exceeds MAX_CREDIT and never underflows; arithmetic is CREDIT_W bits with no wrap.

Reset
REQ-029 While rst_n=0:
- state=IDLE
- credit=0, change=0, item=0
- dispense, change_valid, coin_reject, insufficient all 0
REQ-030 Reset mid-VEND or mid-REFUND aborts it: no dispense or change pulse is produced after reset, and accumulated credit is lost.
REQ-031 Reset takes effect asynchronously and is released synchronously to clk; the first event is sampled on the first rising edge with rst_n=1.

Structure
REQ-032 Shared package vend_pkg holds:
- the FSM state enum
- coin value constants (0/1/2/5)
- default PRICE and MAX_CREDIT constants
REQ-033 One sub-module, price_lut, maps sel to its price combinationally. Everything else lives in credit_ctrl.

Verification
REQ-034 Coins 5,5,2 then buy sel=1: credit 5,10,12; dispense=1 with item=1 one cycle after buy; credit=2; then change_valid=1 with change=2; then credit=0.
REQ-035 Credit 2, buy sel=0: insufficient=1 for one cycle; credit stays 2; no dispense.
REQ-036 Credit 48, coin 5: coin_reject=1; credit stays 48. Then coin 2: credit=50.
REQ-037 Credit 7, buy sel=0 and coin 5 in the same cycle: dispense; credit=2; coin_reject=1. Credit 7, buy and cancel together: change=7; no dispense.
REQ-038 Credit 20, buy sel=3: dispense; credit=0; state returns to IDLE with no change_valid pulse.
REQ-039 Credit 15, buy sel=0, rst_n low in the VEND cycle: all outputs 0 immediately; no change_valid afterwards.
